ser_tx_dev: RTL

Memory-mapped serial transmitter that responds on the processor's shared device bus, alongside the display, LED, key, switch and timer devices. The processor pushes bytes into a small FIFO with SW. The block serialises them on TXD as asynchronous 8N1 frames, or 8E1 with parity compiled in. It raises a level interrupt on INTR when the FIFO has space and interrupts are enabled.

---
 rtl/ser_tx_pkg.sv | 24 ++
 rtl/ser_tx_fifo.sv | 67 ++++++
 rtl/ser_tx_dev.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ser_tx_pkg.sv
// Shared definitions for the memory-mapped serial transmitter.
// Holds the CTRL register bit positions, the transmit FSM state encoding
// and the frame constants used by ser_tx_dev and ser_tx_fifo.
package ser_tx_pkg;

  // CTRL register bit positions
  localparam int unsigned CtrlReadyBit = 0;
  localparam int unsigned CtrlBusyBit  = 1;
  localparam int unsigned CtrlOvrBit   = 2;
  localparam int unsigned CtrlIeBit    = 8;

  // Frame constants
  localparam int unsigned DataBits = 8;
  localparam int unsigned BitIdxW  = $clog2(DataBits);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/ser_tx_fifo.sv
// Synchronous single-clock FIFO for the serial transmitter.
// Ports:
//   clk_i            clock, all updates on posedge
//   init_i           synchronous active-high flush
//   lock_i           clock-valid qualifier; no state changes while low
//   push_i, wdata_i  write request and data (ignored when full)
//   pop_i, rdata_o   read request and head-of-queue data (ignored when empty)
//   full_o, empty_o  occupancy flags
//   count_o          occupancy, 0..2^FABITS
module ser_tx_fifo
  import ser_tx_pkg::*;
#(
  parameter int unsigned FABITS = 2,
  parameter int unsigned Width  = DataBits
) (
  input  logic              clk_i,
  input  logic              init_i,
  input  logic              lock_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [FABITS:0]   count_o
);

  localparam int unsigned Depth = 2 ** FABITS;
  localparam logic [FABITS:0] DepthCnt = Depth[FABITS:0];

  logic [Width-1:0]  mem_q [Depth];
  logic [FABITS-1:0] wptr_q, rptr_q;
  logic [FABITS:0]   count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full/empty are evaluated on pre-edge occupancy, so a push into a full
  // FIFO is rejected even if a pop happens on the same edge.
  assign do_push = lock_i & push_i & ~full_o;
  assign do_pop  = lock_i & pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (!init_i && do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ser_tx_dev.sv
// Memory-mapped serial transmitter on the shared device bus.
// Bytes written to DADDR are queued and sent on TXD as 8N1 frames, or as
// 8E1 frames when the SER_TX_PARITY_EN macro is defined.
// Ports:
//   CLK        clock, all updates on posedge
//   INIT       synchronous active-high reset
//   LOCK       clock-valid qualifier; no state changes while low
//   ABUS       bus address
//   RBUS       read data, driven only during an addressed read, else z
//   RE, WE     read / write enables
//   WBUS       write data
//   INTR       level interrupt: IE && READY, registered
//   TXD        serial line, idle high
// Registers: DADDR write pushes WBUS[7:0], read returns occupancy.
//            CADDR bit0 READY, bit1 BUSY, bit2 OVR (sticky), bit8 IE.
module ser_tx_dev
  import ser_tx_pkg::*;
#(
  parameter int unsigned     ABITS  = 16,
  parameter int unsigned     DBITS  = 16,
  parameter logic [ABITS-1:0] DADDR = 16'hFFE8,
  parameter logic [ABITS-1:0] CADDR = 16'hFFEA,
  parameter int unsigned     FABITS = 2,
  parameter int unsigned     BAUDN  = 434,
  parameter int unsigned     BAUDB  = 9
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             LOCK,
  input  logic [ABITS-1:0] ABUS,
  inout  wire  [DBITS-1:0] RBUS,
  input  logic             RE,
  input  logic [DBITS-1:0] WBUS,
  input  logic             WE,
  output logic             INTR,
  output logic             TXD
);

  localparam logic [BAUDB-1:0]   BaudLast = BAUDB'(BAUDN - 1);
  localparam logic [BitIdxW-1:0] BitLast  = BitIdxW'(DataBits - 1);

  tx_state_e            state_q, state_d;
  logic [BAUDB-1:0]     baud_q, baud_d;
  logic [BitIdxW-1:0]   bit_q, bit_d;
  logic [DataBits-1:0]  shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 ie_q, ie_d;
  logic                 ovr_q, ovr_d;
  logic                 intr_q;
`ifdef SER_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic                 sel_data, sel_ctrl, wr_data, wr_ctrl, rd_hit;
  logic [DBITS-1:0]     ctrl_rd, rd_data;
  logic [DataBits-1:0]  fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [FABITS:0]      fifo_count;
  logic                 baud_end;
  logic                 unused_wbus;

  assign unused_wbus = ^WBUS[DBITS-1:CtrlIeBit+1];

  ser_tx_fifo #(
    .FABITS (FABITS),
    .Width  (DataBits)
  ) u_fifo (
    .clk_i   (CLK),
    .init_i  (INIT),
    .lock_i  (LOCK),
    .push_i  (wr_data),
    .wdata_i (WBUS[DataBits-1:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus decode and register file
  assign sel_data = (ABUS == DADDR);
  assign sel_ctrl = (ABUS == CADDR);
  assign wr_data  = WE & sel_data;
  assign wr_ctrl  = WE & sel_ctrl;
  assign rd_hit   = RE & (sel_data | sel_ctrl);

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CtrlReadyBit] = ~fifo_full;
    ctrl_rd[CtrlBusyBit]  = (state_q != StIdle) | ~fifo_empty;
    ctrl_rd[CtrlOvrBit]   = ovr_q;
    ctrl_rd[CtrlIeBit]    = ie_q;
    rd_data = sel_data ? DBITS'(fifo_count) : ctrl_rd;
  end

  assign RBUS = rd_hit ? rd_data : {DBITS{1'bz}};

  always_comb begin
    ie_d  = wr_ctrl ? WBUS[CtrlIeBit] : ie_q;
    ovr_d = ovr_q;
    if (wr_ctrl && !WBUS[CtrlOvrBit]) ovr_d = 1'b0;
    // An overflow on the same edge as a clearing write wins.
    if (wr_data && fifo_full) ovr_d = 1'b1;
  end

  // Transmit FSM
  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef SER_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef SER_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
`ifdef SER_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef SER_TX_PARITY_EN
      StParity: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // TXD is registered from the next state so the line is glitch-free.
    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
`ifdef SER_TX_PARITY_EN
      StParity: txd_d = parity_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ie_q     <= 1'b0;
      ovr_q    <= 1'b0;
      intr_q   <= 1'b0;
`ifdef SER_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (LOCK) begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ie_q     <= ie_d;
      ovr_q    <= ovr_d;
      // Built from registered values only: no bus-to-INTR path.
      intr_q   <= ie_q & ~fifo_full;
`ifdef SER_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TXD  = txd_q;
  assign INTR = intr_q;

endmodule
